mdio_master: RTL
================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, clk cycles per MDC half-period (legal range 2..255).
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32, number of preamble 1-bits (legal range 0..32).
REQ-003 SHALL have parameter C45_EN, default 1, enables Clause 45 frames; when 0, req_c45 is ignored and treated as 0.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk  in  1  system clock; reset  in  1  async active-high reset.
REQ-005 SHALL have ports: req_valid  in  1  request strobe; req_ready  out  1  block can accept a request; req_c45  in  1  1 = Clause 45 frame.
REQ-006 SHALL have ports: req_op  in  2  OP field; req_phyad  in  5  PHY/port address; req_regad  in  5  register/device address; req_wdata  in  16  write data or C45 address.
REQ-007 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  16  read data; rsp_err  out  1  no turnaround 0 from PHY on a read.
REQ-008 SHALL have ports: mdc  out  1  management clock; mdio_o  out  1  data out; mdio_i  in  1  data in; mdio_t  out  1  tristate enable, 1 = released.

Function
REQ-009 SHALL implement states IDLE, PRE, FRAME, DONE; req_ready = 1 only in IDLE.
REQ-010 SHALL accept a request on the cycle T where req_valid && req_ready, capturing all req_* fields; req_valid outside IDLE SHALL be ignored.
REQ-011 SHALL serialise N = PREAMBLE_LEN + 32 bits MSB-first: preamble 1s, ST (C22 01, C45 00), OP, PHYAD, REGAD, TA, 16 data bits.
REQ-012 SHALL give each bit 2*CLK_DIV cycles: bit k spans T+1+2k*CLK_DIV to T+2(k+1)*CLK_DIV, with mdc = 0 for the first CLK_DIV cycles and mdc = 1 for the second CLK_DIV cycles.
REQ-013 SHALL change mdio_o and mdio_t only at bit boundaries, i.e. when mdc goes low.
REQ-014 SHALL define a read as C22 OP 10, or C45 OP 11 (read) or OP 10 (read-increment); every other combination is a write or address frame.
REQ-015 SHALL drive TA as 1,0 for write and address frames.
REQ-016 SHALL set mdio_t = 1 for both TA bits and all 16 data bits of a read frame; all other frame bits SHALL be driven with mdio_t = 0.
REQ-017 SHALL sample mdio_i on the clk edge at which mdc goes 0->1, for the second TA bit and each data bit of a read, shifting data MSB-first.
REQ-018 SHALL flag rsp_err = 1 if the sampled second TA bit of a read is 1.
REQ-019 SHALL, at cycle T+1+2N*CLK_DIV, enter DONE and pulse rsp_valid for one cycle, with mdc = 0 and mdio_t = 1.
REQ-020 SHALL hold rsp_rdata and rsp_err stable from the rsp_valid cycle until the next rsp_valid.
REQ-021 SHALL return rsp_rdata = 16'h0000 and rsp_err = 0 for write and address frames.
REQ-022 SHALL return from DONE to IDLE on the next cycle, so back-to-back requests are separated by at least 2 cycles.
REQ-023 SHALL skip PRE and enter FRAME directly when PREAMBLE_LEN = 0.
REQ-024 SHALL hold mdc = 0, mdio_o = 1 and mdio_t = 1 in IDLE.
REQ-025 SHALL use a divider counter width of ceil(log2(CLK_DIV)) bits and a bit counter width of 6 bits, with no wrap inside a frame.

Reset
REQ-026 SHALL, on reset assertion, immediately set state = IDLE, mdc = 0, mdio_o = 1, mdio_t = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and all counters to 0.
REQ-027 SHALL, on reset mid-frame, abort the frame without a response, with req_ready = 1 on the first cycle after deassertion.

Verification
REQ-028 SHALL cover: C22 write, phyad 7, regad 0, wdata 16'h1140 -> decoded bitstream 32x1, 01, 01, 00111, 00000, 10, 0001000101000000; rsp_valid at T+1+64*CLK_DIV*2; rsp_err = 0.
REQ-029 SHALL cover: C22 read, phyad 7, regad 1, with the PHY model driving TA 0 and 16'h796D -> rsp_rdata = 16'h796D, rsp_err = 0, mdio_t = 1 over TA and data.
REQ-030 SHALL cover: C22 read with mdio_i held at 1 (no PHY) -> rsp_err = 1, rsp_rdata = 16'hFFFF.
REQ-031 SHALL cover: C45 address frame (OP 00, wdata 16'h0010) followed by a C45 read (OP 11) -> ST bits 00 on both; read returns the model value; req_ready low throughout each frame.
REQ-032 SHALL cover: reset asserted at bit 40 of a write -> mdio_t = 1 and mdc = 0 in the same cycle; no rsp_valid; a following read completes normally.
REQ-033 SHALL cover: PREAMBLE_LEN = 0, CLK_DIV = 2 -> rsp_valid at T+129; and req_valid asserted during a frame -> no extra frame produced.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 / Clause 45 MDIO management master with divided MDC
module mdio_master #(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_EN       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_c45,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  input  logic        mdio_i,
  output logic        mdio_t
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [5:0] PL   = 6'(PREAMBLE_LEN);
  localparam logic [5:0] LAST = 6'(PREAMBLE_LEN + 31);
  localparam logic [5:0] TA1  = 6'(PREAMBLE_LEN + 14);
  localparam logic [5:0] TA2  = 6'(PREAMBLE_LEN + 15);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, FRAME = 2'd2, DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic          mdc_q, mdc_d, mdo_q, mdo_d, mdt_q, mdt_d;
  logic [31:0]   frm_q, frm_d;
  logic          rd_q, rd_d, err_q, err_d, rv_q, rv_d, rerr_q, rerr_d;
  logic [15:0]   sh_q, sh_d, rdata_q, rdata_d;

  logic        req_c45_e, req_rd, half, rise, fall;
  logic [31:0] req_frm;
  logic [5:0]  nxt;
  logic [4:0]  fidx;

  assign req_c45_e = (C45_EN != 0) && req_c45;
  assign req_rd    = req_c45_e ? req_op[1] : (req_op == 2'b10);
  assign req_frm   = {1'b0, !req_c45_e, req_op, req_phyad, req_regad, 2'b10, req_rd ? 16'h0000 : req_wdata};
  assign half      = div_q == DIV_MAX;
  assign rise      = half && !mdc_q;
  assign fall      = half && mdc_q;
  assign nxt       = bit_q + 6'd1;
  assign fidx      = 5'(nxt - PL);

  assign req_ready = state_q == IDLE;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdo_q;
  assign mdio_t    = mdt_q;

  // Next-state: accept in IDLE, run the MDC divider and bit sequencer, report in DONE
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mdc_d   = mdc_q;
    mdo_d   = mdo_q;
    mdt_d   = mdt_q;
    frm_d   = frm_q;
    rd_d    = rd_q;
    err_d   = err_q;
    sh_d    = sh_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = (PREAMBLE_LEN != 0) ? PRE : FRAME;
        div_d   = '0;
        bit_d   = '0;
        mdc_d   = 1'b0;
        mdo_d   = (PREAMBLE_LEN != 0) ? 1'b1 : req_frm[31];
        mdt_d   = 1'b0;
        frm_d   = req_frm;
        rd_d    = req_rd;
        err_d   = 1'b0;
        sh_d    = '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else begin
      div_d = half ? '0 : div_q + 1'b1;
      mdc_d = half ? !mdc_q : mdc_q;
      if (rise && rd_q && bit_q == TA2) err_d = mdio_i;
      if (rise && rd_q && bit_q > TA2) sh_d = {sh_q[14:0], mdio_i};
      if (fall && bit_q == LAST) begin
        state_d = DONE;
        bit_d   = '0;
        mdo_d   = 1'b1;
        mdt_d   = 1'b1;
        rv_d    = 1'b1;
        rdata_d = sh_q;
        rerr_d  = err_q;
      end else if (fall) begin
        bit_d   = nxt;
        state_d = (int'(nxt) < PREAMBLE_LEN) ? PRE : FRAME;
        mdo_d   = (int'(nxt) < PREAMBLE_LEN) ? 1'b1 : frm_q[~fidx];
        mdt_d   = rd_q && nxt >= TA1;
      end
    end
  end

  // State registers; reset aborts any frame and parks the bus released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      mdc_q   <= 1'b0;
      mdo_q   <= 1'b1;
      mdt_q   <= 1'b1;
      frm_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mdc_q   <= mdc_d;
      mdo_q   <= mdo_d;
      mdt_q   <= mdt_d;
      frm_q   <= frm_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end
endmodule
